// File: rtl/pc_stall_unit_if.sv
// ----------------------------------------------------------------------------
// pc_stall_unit_if
//   Bundle between the PC stage and its neighbours (hazard unit, EX redirect,
//   IF/ID stage).
//
//   Parameters
//     ADDR_W : width of the PC and of the redirect target
//     CNT_W  : width of the stall counter
//
//   Signals
//     stall          hazard unit requests that the PC hold
//     redirect       taken branch/jump from EX
//     redirect_addr  redirect target address
//     pc             current fetch address
//     pc_prev        PC value before the most recent update
//     pc_valid       PC stage has left its post-reset state
//     flush          one-cycle squash pulse to IF/ID after a taken redirect
//     stall_cnt      consecutive stalled cycles, saturating
//     stall_timeout  stall has lasted at least the timeout threshold
//     misalign       odd redirect target rejected (alignment-check builds only)
//
//   Modports
//     master : pipeline side; drives stall/redirect and observes the PC
//     slave  : the PC stage itself
// ----------------------------------------------------------------------------
interface pc_stall_unit_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 3
);
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_prev;
    logic              pc_valid;
    logic              flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_timeout;
    logic              misalign;

    modport master (
        output stall,
        output redirect,
        output redirect_addr,
        input  pc,
        input  pc_prev,
        input  pc_valid,
        input  flush,
        input  stall_cnt,
        input  stall_timeout,
        input  misalign
    );

    modport slave (
        input  stall,
        input  redirect,
        input  redirect_addr,
        output pc,
        output pc_prev,
        output pc_valid,
        output flush,
        output stall_cnt,
        output stall_timeout,
        output misalign
    );
endinterface

// File: rtl/pc_stall_unit.sv
// ----------------------------------------------------------------------------
// pc_stall_unit
//   Program-counter stage. Produces the fetch address from three sources in
//   priority order: redirect (branch/jump), stall hold, sequential increment.
//   Counts consecutive stalled cycles in a saturating counter, raises a
//   timeout flag on runaway stalls and pulses a one-cycle flush to IF/ID on
//   every taken redirect. All state changes on the falling clock edge.
//
//   Parameters
//     ADDR_W    : PC / redirect address width
//     INC_STEP  : amount added to the PC on a normal advance
//     RESET_VEC : PC value after reset
//     CNT_W     : stall counter width
//     MAX_STALL : stall count at which stall_timeout is raised
//                 (must not exceed 2**CNT_W-1)
//
//   Ports
//     clk    : pipeline clock, state updates on negedge
//     reset  : asynchronous, active-low reset
//     bus    : pc_stall_unit_if.slave (stall, redirect, redirect_addr in;
//              pc, pc_prev, pc_valid, flush, stall_cnt, stall_timeout,
//              misalign out; all outputs registered)
//
//   Build option
//     PC_ALIGN_CHECK_EN : when defined, a redirect to an odd address is not
//     taken; the cycle behaves as stall/advance and misalign pulses for one
//     cycle instead of flush. When undefined, misalign is constant 0.
// ----------------------------------------------------------------------------
module pc_stall_unit #(
    parameter int                ADDR_W    = 16,
    parameter int                INC_STEP  = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                CNT_W     = 3,
    parameter int                MAX_STALL = 6
) (
    input  logic             clk,
    input  logic             reset,
    pc_stall_unit_if.slave   bus
);

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q,         state_d;
    logic [ADDR_W-1:0] pc_q,            pc_d;
    logic [ADDR_W-1:0] pc_prev_q,       pc_prev_d;
    logic              pc_valid_q,      pc_valid_d;
    logic              flush_q,         flush_d;
    logic [CNT_W-1:0]  stall_cnt_q,     stall_cnt_d;
    logic              stall_timeout_q, stall_timeout_d;
    logic              misalign_q,      misalign_d;

    logic              redirect_take;
    logic              redirect_reject;

    // Counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

`ifdef PC_ALIGN_CHECK_EN
    assign redirect_take   = bus.redirect & ~bus.redirect_addr[0];
    assign redirect_reject = bus.redirect &  bus.redirect_addr[0];
`else
    assign redirect_take   = bus.redirect;
    assign redirect_reject = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pc_prev_d       = pc_prev_q;
        pc_valid_d      = pc_valid_q;
        flush_d         = 1'b0;
        stall_cnt_d     = stall_cnt_q;
        stall_timeout_d = stall_timeout_q;
        misalign_d      = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // First fetch is at the reset vector; stall/redirect ignored.
                pc_valid_d = 1'b1;
                state_d    = ST_RUN;
            end
            default: begin
                misalign_d = redirect_reject;
                if (redirect_take) begin
                    // Redirect wins over stall; the squashed instruction is
                    // removed by the flush pulse.
                    pc_d            = bus.redirect_addr;
                    pc_prev_d       = pc_q;
                    flush_d         = 1'b1;
                    stall_cnt_d     = '0;
                    stall_timeout_d = 1'b0;
                end else if (bus.stall) begin
                    stall_cnt_d     = sat_inc(stall_cnt_q);
                    stall_timeout_d = (int'(sat_inc(stall_cnt_q)) >= MAX_STALL);
                end else begin
                    // Wraps silently from all-ones to zero.
                    pc_d            = pc_q + ADDR_W'(INC_STEP);
                    pc_prev_d       = pc_q;
                    stall_cnt_d     = '0;
                    stall_timeout_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_VEC;
            pc_prev_q       <= RESET_VEC;
            pc_valid_q      <= 1'b0;
            flush_q         <= 1'b0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
            misalign_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_prev_q       <= pc_prev_d;
            pc_valid_q      <= pc_valid_d;
            flush_q         <= flush_d;
            stall_cnt_q     <= stall_cnt_d;
            stall_timeout_q <= stall_timeout_d;
            misalign_q      <= misalign_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_prev       = pc_prev_q;
    assign bus.pc_valid      = pc_valid_q;
    assign bus.flush         = flush_q;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.stall_timeout = stall_timeout_q;
    assign bus.misalign      = misalign_q;

endmodule

// File: tb/tb_pc_stall_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_stall_unit
//   Directed bench for pc_stall_unit (ADDR_W=16, CNT_W=3, MAX_STALL=6).
//   INC_STEP is 1 by default and 2 when PC_ALIGN_CHECK_EN is defined.
//   Inputs change 1 time unit after each falling edge; outputs are checked at
//   the same point, i.e. after the edge has taken effect.
// ----------------------------------------------------------------------------
module tb_pc_stall_unit;

`ifdef PC_ALIGN_CHECK_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    pc_stall_unit_if #(.ADDR_W(16), .CNT_W(3)) bus ();

    pc_stall_unit #(
        .ADDR_W    (16),
        .INC_STEP  (STEP),
        .RESET_VEC (16'h0000),
        .CNT_W     (3),
        .MAX_STALL (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [15:0] ad);
        bus.stall         = st;
        bus.redirect      = rd;
        bus.redirect_addr = ad;
    endtask

    initial begin
        logic [15:0] wrap_top;
        n_vec = 0;
        n_err = 0;
        wrap_top = 16'(32'h10000 - STEP);
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);

        // Reset held while the clock runs
        tick();
        tick();
        chk("rst_pc",       32'(bus.pc),            32'h0000);
        chk("rst_pc_prev",  32'(bus.pc_prev),       32'h0000);
        chk("rst_valid",    32'(bus.pc_valid),      32'd0);
        chk("rst_flush",    32'(bus.flush),         32'd0);
        chk("rst_cnt",      32'(bus.stall_cnt),     32'd0);
        chk("rst_tmo",      32'(bus.stall_timeout), 32'd0);
        chk("rst_misalign", 32'(bus.misalign),      32'd0);

        // Release: BOOT edge keeps reset vector, then advance
        reset = 1'b1;
        tick();
        chk("boot_pc",    32'(bus.pc),       32'h0000);
        chk("boot_valid", 32'(bus.pc_valid), 32'd1);
        tick();
        chk("run1_pc",      32'(bus.pc),      32'(STEP));
        chk("run1_pc_prev", 32'(bus.pc_prev), 32'h0000);

        // Redirect to 0x0010, then stall 9 edges
        drive(1'b0, 1'b1, 16'h0010);
        tick();
        chk("rd10_pc",    32'(bus.pc),    32'h0010);
        chk("rd10_flush", 32'(bus.flush), 32'd1);
        drive(1'b1, 1'b0, 16'h0000);
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("stall%0d_pc", i),  32'(bus.pc),            32'h0010);
            chk($sformatf("stall%0d_cnt", i), 32'(bus.stall_cnt),     32'((i > 7) ? 7 : i));
            chk($sformatf("stall%0d_tmo", i), 32'(bus.stall_timeout), 32'((i >= 6) ? 1 : 0));
            chk($sformatf("stall%0d_flush", i), 32'(bus.flush),       32'd0);
        end
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        chk("unstall_pc",      32'(bus.pc),            32'h0010 + STEP);
        chk("unstall_pc_prev", 32'(bus.pc_prev),       32'h0010);
        chk("unstall_cnt",     32'(bus.stall_cnt),     32'd0);
        chk("unstall_tmo",     32'(bus.stall_timeout), 32'd0);

        // Redirect beats a simultaneous stall
        drive(1'b0, 1'b1, 16'h0020);
        tick();
        drive(1'b1, 1'b0, 16'h0000);
        tick();
        tick();
        chk("pre_rs_cnt", 32'(bus.stall_cnt), 32'd2);
        drive(1'b1, 1'b1, 16'h0100);
        tick();
        chk("rs_pc",      32'(bus.pc),        32'h0100);
        chk("rs_pc_prev", 32'(bus.pc_prev),   32'h0020);
        chk("rs_flush",   32'(bus.flush),     32'd1);
        chk("rs_cnt",     32'(bus.stall_cnt), 32'd0);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        chk("rs_flush_drop", 32'(bus.flush), 32'd0);
        chk("rs_adv_pc",     32'(bus.pc),    32'h0100 + STEP);

        // Back-to-back redirects keep flush high
        drive(1'b0, 1'b1, 16'h0200);
        tick();
        chk("b2b1_flush", 32'(bus.flush), 32'd1);
        drive(1'b0, 1'b1, 16'h0300);
        tick();
        chk("b2b2_flush",   32'(bus.flush),   32'd1);
        chk("b2b2_pc",      32'(bus.pc),      32'h0300);
        chk("b2b2_pc_prev", 32'(bus.pc_prev), 32'h0200);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        chk("b2b_end_flush", 32'(bus.flush), 32'd0);

        // Wrap from the top of the address space
        drive(1'b0, 1'b1, wrap_top);
        tick();
        chk("wrap_top_pc", 32'(bus.pc), 32'(wrap_top));
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        chk("wrap_pc",      32'(bus.pc),      32'h0000);
        chk("wrap_pc_prev", 32'(bus.pc_prev), 32'(wrap_top));
        chk("wrap_flush",   32'(bus.flush),   32'd0);

        // Async reset in the middle of a stall
        tick();
        drive(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 4; i++) tick();
        chk("pre_arst_cnt", 32'(bus.stall_cnt), 32'd4);
        chk("pre_arst_pc",  32'(bus.pc),        32'(STEP));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_pc",      32'(bus.pc),            32'h0000);
        chk("arst_pc_prev", 32'(bus.pc_prev),       32'h0000);
        chk("arst_valid",   32'(bus.pc_valid),      32'd0);
        chk("arst_cnt",     32'(bus.stall_cnt),     32'd0);
        chk("arst_flush",   32'(bus.flush),         32'd0);
        chk("arst_tmo",     32'(bus.stall_timeout), 32'd0);

        // Redirect during BOOT is ignored
        tick();
        drive(1'b0, 1'b1, 16'h0054);
        reset = 1'b1;
        tick();
        chk("boot2_pc",    32'(bus.pc),       32'h0000);
        chk("boot2_flush", 32'(bus.flush),    32'd0);
        chk("boot2_valid", 32'(bus.pc_valid), 32'd1);
        drive(1'b0, 1'b0, 16'h0000);
        tick();
        chk("boot2_adv_pc", 32'(bus.pc), 32'(STEP));

`ifdef PC_ALIGN_CHECK_EN
        // Odd redirect target is refused
        drive(1'b0, 1'b1, 16'h0041);
        tick();
        chk("mis_pc",       32'(bus.pc),       32'(2 * STEP));
        chk("mis_misalign", 32'(bus.misalign), 32'd1);
        chk("mis_flush",    32'(bus.flush),    32'd0);
        drive(1'b0, 1'b1, 16'h0040);
        tick();
        chk("al_pc",       32'(bus.pc),       32'h0040);
        chk("al_flush",    32'(bus.flush),    32'd1);
        chk("al_misalign", 32'(bus.misalign), 32'd0);
        drive(1'b0, 1'b0, 16'h0000);
`else
        // Odd target is taken when no alignment check is built in
        drive(1'b0, 1'b1, 16'h0041);
        tick();
        chk("odd_pc",       32'(bus.pc),       32'h0041);
        chk("odd_flush",    32'(bus.flush),    32'd1);
        chk("odd_misalign", 32'(bus.misalign), 32'd0);
        drive(1'b0, 1'b0, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_stall_unit.md
Name: pc_stall_unit

Overview:
- Parametrised program-counter stage for the CPU pipeline; successor to the fixed 16-bit stall-hold PC register.
- Generates the fetch address with three sources, in priority order: branch/jump redirect, stall hold, sequential increment.
- Tracks stall length in a saturating counter and flags runaway stalls.
- Pulses a one-cycle flush to the IF/ID stage on every taken redirect.

Parameters:
- ADDR_W, 16, width of PC and redirect address
- INC_STEP, 1, sequential increment added to PC per advance (word-addressed memory)
- RESET_VEC, 0, PC value loaded on reset (ADDR_W bits)
- CNT_W, 3, width of stall counter
- MAX_STALL, 6, stall-count threshold for stall_timeout; must be <= 2^CNT_W-1

Ports:
- clk  in  1  pipeline clock; all state updates on negedge clk
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit requests PC hold (load-use etc.)
- redirect  in  1  taken branch/jump from EX
- redirect_addr  in  ADDR_W  target address for redirect
- pc  out  ADDR_W  current fetch address (registered)
- pc_prev  out  ADDR_W  PC value before the most recent update
- pc_valid  out  1  high once the unit has left the post-reset state
- flush  out  1  one-cycle pulse after a taken redirect
- stall_cnt  out  CNT_W  consecutive stalled cycles, saturating
- stall_timeout  out  1  stall_cnt >= MAX_STALL while stall held
- misalign  out  1  see Optional Feature; tied 0 when feature is off

Behaviour:
- reset==0, asynchronous regardless of clk:
  - pc=RESET_VEC, pc_prev=RESET_VEC
  - pc_valid=0, flush=0, stall_cnt=0, stall_timeout=0, misalign=0
  - state=BOOT
- States BOOT, RUN; all transitions on negedge clk.
- BOOT:
  - First negedge after reset release: pc_valid<=1, state<=RUN.
  - pc stays RESET_VEC, so the first fetch is at the reset vector.
  - stall and redirect are ignored in BOOT.
- RUN, evaluated each negedge with priority redirect > stall > advance:
  - Redirect:
    - pc<=redirect_addr, pc_prev<=pc, flush<=1, stall_cnt<=0, stall_timeout<=0.
    - Redirect wins over a simultaneous stall; the stalled younger instruction is squashed by flush.
  - Stall (no redirect):
    - pc, pc_prev hold; flush<=0.
    - stall_cnt<=stall_cnt+1, saturating at 2^CNT_W-1 (no wrap).
    - stall_timeout<=1 when the next stall_cnt >= MAX_STALL.
  - Advance:
    - pc<=pc+INC_STEP, truncated to ADDR_W; wraps from all-ones to 0 without a flag.
    - pc_prev<=pc, flush<=0, stall_cnt<=0, stall_timeout<=0.
- flush is high for exactly one cycle per redirect. Back-to-back redirects keep it high on consecutive cycles.
- Latency: redirect_addr/stall sampled on negedge N appear on pc after negedge N (one-edge registered latency).
- Reset asserted mid-stall or mid-redirect aborts immediately to reset values; no partial update.
- Outputs are all registered; no combinational input-to-output paths.

Optional Feature:
- Macro PC_ALIGN_CHECK_EN.
- Defined:
  - A redirect whose redirect_addr[0]==1 is not taken; RUN treats the cycle as a stall/advance per normal priority, ignoring redirect.
  - That negedge also sets misalign<=1 for one cycle and does not assert flush.
  - Only meaningful with INC_STEP even (byte-addressed builds).
- Not defined: no alignment check; every redirect is taken; misalign is constant 0.

Test Plan:
- Reset: hold reset=0, toggle clk -> pc=0x0000, pc_valid=0, flush=0. Release, then one negedge -> pc=0x0000, pc_valid=1. Next negedge -> pc=0x0001.
- Stall with saturation and timeout (CNT_W=3, MAX_STALL=6):
  - At pc=0x0010, hold stall for 9 negedges.
  - pc stays 0x0010; stall_cnt goes 1..7 and holds at 7.
  - stall_timeout rises on the 6th edge.
  - Drop stall -> pc=0x0011, stall_cnt=0, stall_timeout=0.
- Redirect vs stall:
  - At pc=0x0020 assert stall=1 and redirect=1, redirect_addr=0x0100 for one edge.
  - Expect pc=0x0100, pc_prev=0x0020, flush=1 for exactly one cycle, stall_cnt=0.
- Wrap: ADDR_W=16 with pc=0xFFFF, stall=0 -> pc=0x0000, pc_prev=0xFFFF, no flush.
- Async reset mid-operation:
  - Drive reset=0 between clock edges while stall_cnt=4.
  - All outputs take reset values immediately, before the next edge.
- PC_ALIGN_CHECK_EN defined, INC_STEP=2:
  - redirect_addr=0x0041 -> pc advances by 2, misalign=1 for one cycle, flush=0.
  - redirect_addr=0x0040 -> pc=0x0040, flush=1.
